// File: rtl/ball_collision_referee_if.sv
// Ball/paddle position inputs and referee result outputs, bundled for the referee port.
// The master side is the ball/paddle logic; the slave side is the referee.
interface ball_collision_referee_if;
    logic        i_Space;
    logic [10:0] i_Ball_X;
    logic [10:0] i_Ball_Y;
    logic        i_Ball_Dir_Y;
    logic [10:0] i_Paddle_X;
    logic        o_Paddle_Hit;
    logic        o_Lose;
    logic [7:0]  o_Score;
    logic [3:0]  o_Lives;
    logic        o_Game_Over;
    logic [1:0]  o_State;

    modport master (
        output i_Space, i_Ball_X, i_Ball_Y, i_Ball_Dir_Y, i_Paddle_X,
        input  o_Paddle_Hit, o_Lose, o_Score, o_Lives, o_Game_Over, o_State
    );

    modport slave (
        input  i_Space, i_Ball_X, i_Ball_Y, i_Ball_Dir_Y, i_Paddle_X,
        output o_Paddle_Hit, o_Lose, o_Score, o_Lives, o_Game_Over, o_State
    );
endinterface

// File: rtl/ball_collision_referee.sv
// Game referee: detects paddle hits and misses, keeps a BCD score and a life count,
// and sequences the round through idle, play, miss cool-down and game over.
module ball_collision_referee #(
    parameter int unsigned PADDLE_ROW   = 28,
    parameter int unsigned PADDLE_WIDTH = 6,
    parameter int unsigned BOTTOM_ROW   = 30,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned MISS_HOLD    = 50
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    ball_collision_referee_if.slave  io_Referee
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StPlay     = 2'b01,
        StMiss     = 2'b10,
        StGameOver = 2'b11
    } t_State;

    localparam int unsigned CNT_W = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;

    localparam logic [10:0]      CONTACT_ROW = 11'(PADDLE_ROW - 1);
    localparam logic [10:0]      LOSE_ROW    = 11'(BOTTOM_ROW);
    localparam logic [11:0]      WIDTH_M1    = 12'(PADDLE_WIDTH - 1);
    localparam logic [3:0]       LIVES_INIT  = 4'(LIVES);
    localparam logic [CNT_W-1:0] MISS_LOAD   = CNT_W'(MISS_HOLD - 1);

    t_State           r_State;
    logic             r_Space_Q;
    logic             r_Armed;
    logic [CNT_W-1:0] r_Miss_Cnt;
    logic             r_Paddle_Hit;
    logic             r_Lose;
    logic [7:0]       r_Score;
    logic [3:0]       r_Lives;
    logic             r_Game_Over;

    logic        w_Space_Rise;
    logic        w_On_Row;
    logic [11:0] w_Span_Right;
    logic        w_In_Span;
    logic        w_Hit;
    logic        w_Lose;
    logic [7:0]  w_Score_Inc;

    assign w_Space_Rise = io_Referee.i_Space & ~r_Space_Q;
    assign w_On_Row     = (io_Referee.i_Ball_Y == CONTACT_ROW);

    // Right edge is formed in 12 bits so a paddle near X=2047 does not wrap.
    assign w_Span_Right = {1'b0, io_Referee.i_Paddle_X} + WIDTH_M1;
    assign w_In_Span    = (io_Referee.i_Ball_X >= io_Referee.i_Paddle_X) &&
                          ({1'b0, io_Referee.i_Ball_X} <= w_Span_Right);

    assign w_Hit  = r_Armed & w_On_Row & io_Referee.i_Ball_Dir_Y & w_In_Span;
    assign w_Lose = (io_Referee.i_Ball_Y >= LOSE_ROW);

    always_comb begin
        w_Score_Inc = r_Score;
        if (r_Score == 8'h99) begin
            w_Score_Inc = 8'h99;
        end else if (r_Score[3:0] == 4'd9) begin
            w_Score_Inc = {r_Score[7:4] + 4'd1, 4'd0};
        end else begin
            w_Score_Inc = {r_Score[7:4], r_Score[3:0] + 4'd1};
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State      <= StIdle;
            r_Space_Q    <= 1'b1;
            r_Armed      <= 1'b1;
            r_Miss_Cnt   <= '0;
            r_Paddle_Hit <= 1'b0;
            r_Lose       <= 1'b0;
            r_Score      <= 8'h00;
            r_Lives      <= LIVES_INIT;
            r_Game_Over  <= 1'b0;
        end else begin
            r_Space_Q    <= io_Referee.i_Space;
            r_Paddle_Hit <= 1'b0;
            r_Lose       <= 1'b0;

            // One hit per contact: re-arm only once the ball has left the contact row.
            if (!w_On_Row) begin
                r_Armed <= 1'b1;
            end

            case (r_State)
                StIdle: begin
                    if (w_Space_Rise) begin
                        r_State <= StPlay;
                        r_Armed <= 1'b1;
                    end
                end

                StPlay: begin
                    if (w_Lose) begin
                        r_Lose  <= 1'b1;
                        r_Lives <= r_Lives - 4'd1;
                        if (r_Lives <= 4'd1) begin
                            r_State     <= StGameOver;
                            r_Game_Over <= 1'b1;
                        end else begin
                            r_State    <= StMiss;
                            r_Miss_Cnt <= MISS_LOAD;
                        end
                    end else if (w_Hit) begin
                        r_Paddle_Hit <= 1'b1;
                        r_Score      <= w_Score_Inc;
                        r_Armed      <= 1'b0;
                    end
                end

                StMiss: begin
                    if (r_Miss_Cnt == '0) begin
                        r_State <= StIdle;
                    end else begin
                        r_Miss_Cnt <= r_Miss_Cnt - 1'b1;
                    end
                end

                StGameOver: begin
                    if (w_Space_Rise) begin
                        r_State     <= StIdle;
                        r_Score     <= 8'h00;
                        r_Lives     <= LIVES_INIT;
                        r_Game_Over <= 1'b0;
                    end
                end

                default: begin
                    r_State     <= StIdle;
                    r_Game_Over <= 1'b0;
                end
            endcase
        end
    end

    assign io_Referee.o_Paddle_Hit = r_Paddle_Hit;
    assign io_Referee.o_Lose       = r_Lose;
    assign io_Referee.o_Score      = r_Score;
    assign io_Referee.o_Lives      = r_Lives;
    assign io_Referee.o_Game_Over  = r_Game_Over;
    assign io_Referee.o_State      = r_State;

endmodule

// File: tb/tb_ball_collision_referee.sv
// Directed bench for ball_collision_referee: reset, hit window edges, BCD score,
// miss cool-down, game over and reset during a miss.
module tb_ball_collision_referee;

    logic i_Clock;
    logic i_Reset;
    int   n_Checks;
    int   n_Pass;

    ball_collision_referee_if u_Bus ();

    ball_collision_referee #(
        .PADDLE_ROW   (28),
        .PADDLE_WIDTH (6),
        .BOTTOM_ROW   (30),
        .LIVES        (3),
        .MISS_HOLD    (50)
    ) u_Dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .io_Referee (u_Bus)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_Checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_Pass++;
        end
    endtask

    task automatic start_play();
        u_Bus.i_Space = 1'b0;
        tick();
        u_Bus.i_Space = 1'b1;
        tick();
    endtask

    task automatic try_hit(input logic [10:0] x, input logic dir, input logic [10:0] px,
                           output int hits);
        u_Bus.i_Ball_Y = 11'd26;
        tick();
        u_Bus.i_Ball_X     = x;
        u_Bus.i_Ball_Dir_Y = dir;
        u_Bus.i_Paddle_X   = px;
        u_Bus.i_Ball_Y     = 11'd27;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            hits += int'(u_Bus.o_Paddle_Hit);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (u_Bus.o_State == 2'b00) break;
            tick();
        end
    endtask

    initial begin
        int hits;
        int loses;
        int total;
        int miss_cycles;

        n_Checks = 0;
        n_Pass   = 0;
        i_Reset  = 1'b1;
        u_Bus.i_Space      = 1'b1;
        u_Bus.i_Ball_X     = 11'd0;
        u_Bus.i_Ball_Y     = 11'd10;
        u_Bus.i_Ball_Dir_Y = 1'b1;
        u_Bus.i_Paddle_X   = 11'd10;

        tick();
        tick();
        check("rst_state", 32'(u_Bus.o_State), 32'd0);
        check("rst_score", 32'(u_Bus.o_Score), 32'h00);
        check("rst_lives", 32'(u_Bus.o_Lives), 32'd3);
        check("rst_gameover", 32'(u_Bus.o_Game_Over), 32'd0);
        check("rst_strobes", 32'({u_Bus.o_Paddle_Hit, u_Bus.o_Lose}), 32'd0);

        i_Reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("held_space_no_start", 32'(u_Bus.o_State), 32'd0);

        start_play();
        check("start_play", 32'(u_Bus.o_State), 32'd1);

        // Ball parked on the contact row for 40 cycles.
        u_Bus.i_Ball_X = 11'd12;
        u_Bus.i_Ball_Y = 11'd27;
        tick();
        check("hit_latency", 32'(u_Bus.o_Paddle_Hit), 32'd1);
        check("score_01", 32'(u_Bus.o_Score), 32'h01);
        hits = 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            hits += int'(u_Bus.o_Paddle_Hit);
        end
        check("dwell_single_hit", 32'(hits), 32'd0);

        try_hit(11'd12, 1'b1, 11'd10, hits);
        check("rearm_hit", 32'(hits), 32'd1);
        check("score_02", 32'(u_Bus.o_Score), 32'h02);

        try_hit(11'd15, 1'b1, 11'd10, hits);
        check("edge_right_in", 32'(hits), 32'd1);
        try_hit(11'd16, 1'b1, 11'd10, hits);
        check("edge_right_out", 32'(hits), 32'd0);
        try_hit(11'd9, 1'b1, 11'd10, hits);
        check("edge_left_out", 32'(hits), 32'd0);
        try_hit(11'd12, 1'b0, 11'd10, hits);
        check("dir_away", 32'(hits), 32'd0);
        try_hit(11'd2047, 1'b1, 11'd2045, hits);
        check("no_wrap_hit", 32'(hits), 32'd1);
        check("score_04", 32'(u_Bus.o_Score), 32'h04);

        total = 0;
        for (int k = 0; k < 5; k++) begin
            try_hit(11'd12, 1'b1, 11'd10, hits);
            total += hits;
        end
        check("five_hits", 32'(total), 32'd5);
        check("score_09", 32'(u_Bus.o_Score), 32'h09);
        try_hit(11'd12, 1'b1, 11'd10, hits);
        check("score_10", 32'(u_Bus.o_Score), 32'h10);
        for (int k = 0; k < 89; k++) try_hit(11'd12, 1'b1, 11'd10, hits);
        check("score_99", 32'(u_Bus.o_Score), 32'h99);
        try_hit(11'd12, 1'b1, 11'd10, hits);
        check("sat_hit_strobe", 32'(hits), 32'd1);
        check("score_sat", 32'(u_Bus.o_Score), 32'h99);

        // First loss and the cool-down that follows.
        u_Bus.i_Ball_Y = 11'd30;
        tick();
        check("lose_strobe", 32'(u_Bus.o_Lose), 32'd1);
        check("lives_2", 32'(u_Bus.o_Lives), 32'd2);
        check("state_miss", 32'(u_Bus.o_State), 32'd2);
        miss_cycles = 1;
        hits = 0;
        loses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            hits  += int'(u_Bus.o_Paddle_Hit);
            loses += int'(u_Bus.o_Lose);
            if (u_Bus.o_State != 2'b10) break;
            miss_cycles++;
        end
        check("miss_len", 32'(miss_cycles), 32'd50);
        check("miss_to_idle", 32'(u_Bus.o_State), 32'd0);
        check("miss_no_strobes", 32'(hits + loses), 32'd0);

        // Loss coinciding with an otherwise valid hit.
        u_Bus.i_Ball_Y = 11'd10;
        start_play();
        u_Bus.i_Ball_X = 11'd12;
        u_Bus.i_Ball_Y = 11'd30;
        tick();
        check("prio_lose", 32'(u_Bus.o_Lose), 32'd1);
        check("prio_no_hit", 32'(u_Bus.o_Paddle_Hit), 32'd0);
        check("lives_1", 32'(u_Bus.o_Lives), 32'd1);
        wait_idle();

        u_Bus.i_Ball_Y = 11'd10;
        start_play();
        u_Bus.i_Ball_Y = 11'd30;
        tick();
        check("lives_0", 32'(u_Bus.o_Lives), 32'd0);
        check("state_gameover", 32'(u_Bus.o_State), 32'd3);
        check("game_over_flag", 32'(u_Bus.o_Game_Over), 32'd1);
        start_play();
        check("go_to_idle", 32'(u_Bus.o_State), 32'd0);
        check("go_score_clr", 32'(u_Bus.o_Score), 32'h00);
        check("go_lives_reload", 32'(u_Bus.o_Lives), 32'd3);
        check("go_flag_clr", 32'(u_Bus.o_Game_Over), 32'd0);

        // Reset in the middle of the cool-down.
        u_Bus.i_Ball_Y = 11'd10;
        start_play();
        u_Bus.i_Ball_Y = 11'd30;
        tick();
        for (int i = 0; i < 19; i++) tick();
        check("mid_miss_state", 32'(u_Bus.o_State), 32'd2);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        check("mid_miss_rst_state", 32'(u_Bus.o_State), 32'd0);
        check("mid_miss_rst_lives", 32'(u_Bus.o_Lives), 32'd3);

        // Reset on the edge that would issue a hit.
        u_Bus.i_Ball_Y = 11'd10;
        start_play();
        u_Bus.i_Ball_X = 11'd12;
        u_Bus.i_Ball_Y = 11'd27;
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        check("rst_kills_hit", 32'(u_Bus.o_Paddle_Hit), 32'd0);
        check("rst_kills_score", 32'(u_Bus.o_Score), 32'h00);

        $display("%0d/%0d checks passed", n_Pass, n_Checks);
        $finish;
    end

endmodule
